// File: rtl/bist_pkg.sv
// Shared constants for the CUT BIST engine: register width, LFSR taps, counter width,
// FSM state encoding and the shared shift/feedback helper.
package bist_pkg;

  localparam int unsigned W  = 7;
  localparam int unsigned CW = 10;

  // x^7 + x^6 + 1: feedback from bits 6 and 5
  localparam logic [W-1:0] TAPS = 7'h60;

  typedef logic [2:0] bist_state_t;

  localparam bist_state_t StIdle  = 3'd0;
  localparam bist_state_t StLoad  = 3'd1;
  localparam bist_state_t StRun   = 3'd2;
  localparam bist_state_t StDrain = 3'd3;
  localparam bist_state_t StDone  = 3'd4;

  function automatic logic [W-1:0] lfsr_shift(input logic [W-1:0] q);
    return {q[W-2:0], ^(q & TAPS)};
  endfunction

endpackage

// File: rtl/bist_lfsr7.sv
// 7-bit Fibonacci shift register with parallel-XOR input; xor_i tied to 0 gives the
// pattern LFSR, fed with responses gives the MISR.
module bist_lfsr7
  import bist_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] xor_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = lfsr_shift(q_q) ^ xor_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cut_bist_engine.sv
// Logic BIST engine: LFSR pattern source, latency-aligned MISR compaction, run FSM.
// Optional macro BIST_X_MASK_EN adds resp_mask_i to zero unknown response bits.
module cut_bist_engine
  import bist_pkg::*;
#(
  parameter int unsigned  PAT_COUNT  = 127,
  parameter logic [W-1:0] LFSR_SEED  = 7'h01,
  parameter int unsigned  RESP_LAT   = 1,
  parameter logic [W-1:0] GOLDEN_SIG = 7'h00
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] resp_i,
`ifdef BIST_X_MASK_EN
  input  logic [W-1:0] resp_mask_i,
`endif
  output logic [W-1:0] pat_o,
  output logic         pat_vld_o,
  output logic         cut_rst_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic [W-1:0] sig_o
);

  localparam int unsigned  PatEff    = (PAT_COUNT == 0) ? 1 : PAT_COUNT;
  localparam logic [CW-1:0] PatLast   = CW'(PatEff - 1);
  localparam logic [CW-1:0] DrainLast = (RESP_LAT == 0) ? '0 : CW'(RESP_LAT - 1);
  localparam logic [W-1:0]  SeedEff   = (LFSR_SEED == '0) ? W'(1) : LFSR_SEED;

  bist_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  lfsr_q, misr_q, resp_m;
  logic          in_load, pat_vld, busy, cap_vld, dly_clr;

  assign in_load = (state_q == StLoad);
  assign pat_vld = (state_q == StRun);
  assign busy    = (state_q == StLoad) || (state_q == StRun) || (state_q == StDrain);

`ifdef BIST_X_MASK_EN
  assign resp_m = resp_i & ~resp_mask_i;
`else
  assign resp_m = resp_i;
`endif

  // cnt_q counts issued patterns in RUN, then is reused to time DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = abort_i ? StIdle : StRun;
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cnt_q == PatLast) begin
          cnt_d   = '0;
          state_d = (RESP_LAT == 0) ? StDone : StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush in-flight capture strobes so an aborted run cannot leak into the next one
  assign dly_clr = in_load || (busy && abort_i);

  if (RESP_LAT == 0) begin : g_no_dly
    assign cap_vld = pat_vld;
  end else begin : g_dly
    logic [RESP_LAT-1:0] dly_q;
    always_ff @(posedge CK) begin
      if (RST || dly_clr) begin
        dly_q <= '0;
      end else begin
        dly_q[0] <= pat_vld;
        for (int i = 1; i < RESP_LAT; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end
    assign cap_vld = dly_q[RESP_LAT-1];
  end

  bist_lfsr7 u_lfsr (
    .clk_i      (CK),
    .rst_i      (RST),
    .load_i     (in_load),
    .load_val_i (SeedEff),
    .en_i       (pat_vld),
    .xor_i      ('0),
    .q_o        (lfsr_q)
  );

  bist_lfsr7 u_misr (
    .clk_i      (CK),
    .rst_i      (RST),
    .load_i     (in_load),
    .load_val_i ('0),
    .en_i       (cap_vld),
    .xor_i      (resp_m),
    .q_o        (misr_q)
  );

  assign pat_o     = pat_vld ? lfsr_q : '0;
  assign pat_vld_o = pat_vld;
  assign cut_rst_o = in_load;
  assign busy_o    = busy;
  assign done_o    = (state_q == StDone);
  assign pass_o    = (state_q == StDone) && (misr_q == GOLDEN_SIG);
  assign sig_o     = misr_q;

endmodule
